// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word and register-index widths, writeback source
// select encoding and the MEM/WB access-tracking state encoding.
package cpu_types_pkg;

  localparam int WORD_W_DEFAULT = 32;
  localparam int REG_W          = 5;

  typedef logic [WORD_W_DEFAULT-1:0] word_t;
  typedef logic [REG_W-1:0]          regbits_t;

  typedef enum logic [1:0] {
    ALU  = 2'd0,
    LOAD = 2'd1,
    NPC  = 2'd2,
    LUI  = 2'd3
  } regsel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } wb_state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB handshake bundle: EX/MEM latch values, hazard controls, data-memory
// status in; register-file write port, stall and halt status out.
interface mem_wb_stage_if #(parameter int WORD_W = 32);
  logic              flush;
  logic              wben;
  logic              dmemREN;
  logic              dmemWEN;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  logic [WORD_W-1:0] nPC;
  logic [WORD_W-1:0] ALUOut;
  logic [WORD_W-1:0] lui;
  logic              regWr;
  logic [1:0]        regSel;
  logic [4:0]        regDst;
  logic              halt;
  logic              mem_stall;
  logic              rf_WEN;
  logic [4:0]        rf_wsel;
  logic [WORD_W-1:0] rf_wdat;
  logic              wb_valid;
  logic              halt_out;

  modport master (
    output flush, wben, dmemREN, dmemWEN, dhit, dmemload,
           nPC, ALUOut, lui, regWr, regSel, regDst, halt,
    input  mem_stall, rf_WEN, rf_wsel, rf_wdat, wb_valid, halt_out
  );

  modport slave (
    input  flush, wben, dmemREN, dmemWEN, dhit, dmemload,
           nPC, ALUOut, lui, regWr, regSel, regDst, halt,
    output mem_stall, rf_WEN, rf_wsel, rf_wdat, wb_valid, halt_out
  );
endinterface

// File: rtl/mem_wb_stage_wb_mux.sv
// Writeback value select: picks ALU result, load data, link PC or LUI value.
module wb_mux
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  regsel_t           sel_i,
  input  logic [WORD_W-1:0] alu_i,
  input  logic [WORD_W-1:0] load_i,
  input  logic [WORD_W-1:0] npc_i,
  input  logic [WORD_W-1:0] lui_i,
  output logic [WORD_W-1:0] value_o
);

  // source select
  always_comb begin
    value_o = alu_i;
    case (sel_i)
      ALU:     value_o = alu_i;
      LOAD:    value_o = load_i;
      NPC:     value_o = npc_i;
      LUI:     value_o = lui_i;
      default: value_o = alu_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: tracks outstanding data-memory accesses, buffers load
// data that returns while WB is blocked, and drives the register-file write port.
module mem_wb_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input logic          CLK,
  input logic          nRST,
  mem_wb_stage_if.slave bus
);

  wb_state_t         state_q, state_d;
  logic [WORD_W-1:0] ldbuf_q, ldbuf_d;

  logic              valid_q, valid_d;
  logic              regwr_q, regwr_d;
  regbits_t          dst_q,   dst_d;
  logic [WORD_W-1:0] value_q, value_d;
  logic              halt_out_q, halt_out_d;

  logic              mem_req_s;
  logic              stall_s;
  logic              load_s;
  logic [WORD_W-1:0] load_data_s;
  logic [WORD_W-1:0] sel_value_s;

  assign mem_req_s   = bus.dmemREN | bus.dmemWEN;
  assign load_data_s = (state_q == HELD) ? ldbuf_q : bus.dmemload;
  assign load_s      = bus.wben & ~stall_s & ~bus.flush;

  wb_mux #(.WORD_W(WORD_W)) u_wb_mux (
    .sel_i   (regsel_t'(bus.regSel)),
    .alu_i   (bus.ALUOut),
    .load_i  (load_data_s),
    .npc_i   (bus.nPC),
    .lui_i   (bus.lui),
    .value_o (sel_value_s)
  );

  // stall: a halted core stays frozen; buffered load data never stalls
  always_comb begin
    if (halt_out_q) begin
      stall_s = 1'b1;
    end else if (state_q == HELD) begin
      stall_s = 1'b0;
    end else begin
      stall_s = mem_req_s & ~bus.dhit;
    end
  end

  // access-tracking next state and load-data capture
  always_comb begin
    state_d = state_q;
    ldbuf_d = ldbuf_q;
    case (state_q)
      IDLE: begin
        if (mem_req_s & ~bus.dhit) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.dhit) begin
          if (bus.wben) begin
            state_d = IDLE;
          end else begin
            state_d = HELD;
            ldbuf_d = bus.dmemload;
          end
        end else begin
          state_d = WAIT;
        end
      end
      HELD: begin
        if (bus.wben) begin
          state_d = IDLE;
        end else begin
          state_d = HELD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // WB register next value: flush beats stall beats load, otherwise hold
  always_comb begin
    valid_d    = valid_q;
    regwr_d    = regwr_q;
    dst_d      = dst_q;
    value_d    = value_q;
    halt_out_d = halt_out_q | (load_s & bus.halt);
    if (bus.flush | stall_s) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
      dst_d   = '0;
      value_d = '0;
    end else if (bus.wben) begin
      valid_d = 1'b1;
      regwr_d = bus.regWr;
      dst_d   = bus.regDst;
      value_d = sel_value_s;
    end else begin
      valid_d = valid_q;
    end
  end

  // state and WB register flops
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ldbuf_q    <= '0;
      valid_q    <= 1'b0;
      regwr_q    <= 1'b0;
      dst_q      <= '0;
      value_q    <= '0;
      halt_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ldbuf_q    <= ldbuf_d;
      valid_q    <= valid_d;
      regwr_q    <= regwr_d;
      dst_q      <= dst_d;
      value_q    <= value_d;
      halt_out_q <= halt_out_d;
    end
  end

  assign bus.mem_stall = stall_s;
  assign bus.rf_WEN    = valid_q & regwr_q & (dst_q != 5'd0) & ~halt_out_q;
  assign bus.rf_wsel   = dst_q;
  assign bus.rf_wdat   = value_q;
  assign bus.wb_valid  = valid_q;
  assign bus.halt_out  = halt_out_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural model
// that tracks "access outstanding" / "data parked" flags and the WB contents.
module tb_mem_wb_stage;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_wb_stage_if #(.WORD_W(32)) bus ();

  mem_wb_stage #(.WORD_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_outstanding;
  bit          m_parked;
  logic [31:0] m_park_data;
  bit          m_valid;
  bit          m_regwr;
  logic [4:0]  m_dst;
  logic [31:0] m_value;
  bit          m_halted;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_stall();
    if (m_halted) return 1'b1;
    if (m_parked) return 1'b0;
    return (bus.dmemREN | bus.dmemWEN) & ~bus.dhit;
  endfunction

  task automatic model_reset();
    m_outstanding = 0; m_parked = 0; m_park_data = 32'd0;
    m_valid = 0; m_regwr = 0; m_dst = 5'd0; m_value = 32'd0; m_halted = 0;
  endtask

  task automatic model_step();
    bit          stall;
    logic [31:0] v;
    stall = exp_stall();
    case (bus.regSel)
      2'd0:    v = bus.ALUOut;
      2'd1:    v = m_parked ? m_park_data : bus.dmemload;
      2'd2:    v = bus.nPC;
      default: v = bus.lui;
    endcase
    if (!bus.flush && !stall && bus.wben && bus.halt) m_halted = 1;
    if (bus.flush || stall) begin
      m_valid = 0; m_regwr = 0; m_dst = 5'd0; m_value = 32'd0;
    end else if (bus.wben) begin
      m_valid = 1; m_regwr = bus.regWr; m_dst = bus.regDst; m_value = v;
    end
    if (m_parked) begin
      if (bus.wben) m_parked = 0;
    end else if (m_outstanding) begin
      if (bus.dhit) begin
        m_outstanding = 0;
        if (!bus.wben) begin
          m_parked = 1;
          m_park_data = bus.dmemload;
        end
      end
    end else if ((bus.dmemREN | bus.dmemWEN) && !bus.dhit) begin
      m_outstanding = 1;
    end
  endtask

  task automatic check_outputs();
    check_val("rf_WEN",   32'(bus.rf_WEN),   32'(m_valid & m_regwr & (m_dst != 5'd0) & ~m_halted));
    check_val("rf_wsel",  32'(bus.rf_wsel),  32'(m_dst));
    check_val("rf_wdat",  bus.rf_wdat,       m_value);
    check_val("wb_valid", 32'(bus.wb_valid), 32'(m_valid));
    check_val("halt_out", 32'(bus.halt_out), 32'(m_halted));
  endtask

  // called at posedge+1 with new inputs already applied
  task automatic cycle();
    #1;
    check_val("mem_stall", 32'(bus.mem_stall), 32'(exp_stall()));
    @(posedge CLK);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive_idle();
    bus.flush = 0; bus.wben = 1; bus.dmemREN = 0; bus.dmemWEN = 0; bus.dhit = 0;
    bus.dmemload = 32'd0; bus.nPC = 32'd0; bus.ALUOut = 32'd0; bus.lui = 32'd0;
    bus.regWr = 0; bus.regSel = 2'd0; bus.regDst = 5'd0; bus.halt = 0;
  endtask

  task automatic apply_reset();
    nRST = 0;
    model_reset();
    #1;
    check_outputs();
    check_val("rst_stall", 32'(bus.mem_stall), 32'((bus.dmemREN | bus.dmemWEN) & ~bus.dhit));
    @(posedge CLK);
    #3;
    nRST = 1;
  endtask

  task automatic drive_random();
    bus.flush    = ($urandom_range(0, 7) == 0);
    bus.wben     = ($urandom_range(0, 3) != 0);
    bus.dmemREN  = ($urandom_range(0, 2) == 0);
    bus.dmemWEN  = ($urandom_range(0, 6) == 0);
    bus.dhit     = ($urandom_range(0, 1) == 0);
    bus.dmemload = $urandom;
    bus.nPC      = $urandom;
    bus.ALUOut   = $urandom;
    bus.lui      = $urandom;
    bus.regWr    = ($urandom_range(0, 3) != 0);
    bus.regSel   = 2'($urandom_range(0, 3));
    bus.regDst   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    bus.halt     = 0;
  endtask

  initial begin
    drive_idle();
    nRST = 0;
    model_reset();
    #2;
    check_outputs();
    check_val("rst_stall0", 32'(bus.mem_stall), 32'd0);
    @(posedge CLK);
    #3;
    nRST = 1;

    // simple ALU writeback
    drive_idle();
    bus.ALUOut = 32'h1234; bus.regWr = 1; bus.regDst = 5'd5;
    cycle();
    check_val("alu_wen",  32'(bus.rf_WEN),  32'd1);
    check_val("alu_wsel", 32'(bus.rf_wsel), 32'd5);
    check_val("alu_wdat", bus.rf_wdat,      32'h1234);

    // load miss for 3 cycles then hit
    drive_idle();
    bus.dmemREN = 1; bus.regSel = 2'd1; bus.regWr = 1; bus.regDst = 5'd8;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("miss_stall", 32'(bus.mem_stall), 32'd1);
    end
    bus.dhit = 1; bus.dmemload = 32'hCAFEF00D;
    cycle();
    check_val("hit_wdat", bus.rf_wdat,     32'hCAFEF00D);
    check_val("hit_wen",  32'(bus.rf_WEN), 32'd1);
    drive_idle();
    cycle();
    check_val("hit_once", 32'(bus.rf_WEN), 32'd0);

    // data returns while WB blocked: must be parked and used later
    bus.dmemREN = 1; bus.regSel = 2'd1; bus.regWr = 1; bus.regDst = 5'd9;
    cycle();
    bus.dhit = 1; bus.wben = 0; bus.dmemload = 32'hCAFEF00D;
    cycle();
    bus.dhit = 0; bus.dmemload = 32'd0;
    cycle();
    check_val("held_nostall", 32'(bus.mem_stall), 32'd0);
    bus.wben = 1;
    cycle();
    check_val("held_wdat", bus.rf_wdat,     32'hCAFEF00D);
    check_val("held_wen",  32'(bus.rf_WEN), 32'd1);

    // flush beats wben
    drive_idle();
    bus.flush = 1; bus.regWr = 1; bus.regDst = 5'd7; bus.ALUOut = 32'h55;
    cycle();
    check_val("flush_valid", 32'(bus.wb_valid), 32'd0);
    check_val("flush_wen",   32'(bus.rf_WEN),   32'd0);

    // r0 never written
    drive_idle();
    bus.regWr = 1; bus.regDst = 5'd0; bus.ALUOut = 32'hFFFF;
    cycle();
    check_val("r0_wen", 32'(bus.rf_WEN), 32'd0);

    // reset in the middle of an outstanding access
    drive_idle();
    bus.dmemREN = 1; bus.regSel = 2'd1; bus.regWr = 1; bus.regDst = 5'd4;
    cycle();
    cycle();
    apply_reset();
    drive_idle();
    bus.wben = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("post_rst_wen", 32'(bus.rf_WEN), 32'd0);
    end

    // randomized traffic, one reset partway through
    for (int n = 0; n < 400; n++) begin
      drive_random();
      if (n == 200) apply_reset();
      cycle();
    end

    // halt is sticky across flush, cleared only by reset
    drive_idle();
    cycle();
    bus.halt = 1; bus.regWr = 1; bus.regDst = 5'd3;
    cycle();
    check_val("halt_set", 32'(bus.halt_out), 32'd1);
    drive_idle();
    bus.flush = 1;
    cycle();
    check_val("halt_flush", 32'(bus.halt_out), 32'd1);
    check_val("halt_stall", 32'(bus.mem_stall), 32'd1);
    bus.flush = 0; bus.regWr = 1; bus.regDst = 5'd6;
    cycle();
    check_val("halt_nowen", 32'(bus.rf_WEN), 32'd0);
    apply_reset();
    check_val("halt_rst", 32'(bus.halt_out), 32'd0);
    drive_idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter WORD_W, default 32: datapath width.
REQ-002 SHALL have port CLK, input, 1: clock, rising-edge.
REQ-003 SHALL have port nRST, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port flush, input, 1: squash the WB register (insert bubble).
REQ-005 SHALL have port wben, input, 1: WB register load enable from the hazard unit.
REQ-006 SHALL have ports dmemREN and dmemWEN, input, 1 each: pending data-memory read/write from the EX/MEM latch.
REQ-007 SHALL have port dhit, input, 1: data-memory access complete this cycle.
REQ-008 SHALL have port dmemload, input, WORD_W: read data, valid when dhit=1.
REQ-009 SHALL have ports nPC, ALUOut and lui, input, WORD_W each: candidate writeback values.
REQ-010 SHALL have ports regWr (1), regSel (2) and regDst (5), input: writeback control.
REQ-011 SHALL have port halt, input, 1: halt instruction in MEM.
REQ-012 SHALL have port mem_stall, output, 1: freeze all upstream stages.
REQ-013 SHALL have ports rf_WEN (1), rf_wsel (5) and rf_wdat (WORD_W), output: register-file write port.
REQ-014 SHALL have port wb_valid, output, 1: WB holds a real instruction.
REQ-015 SHALL have port halt_out, output, 1: sticky processor halt.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, HELD.
REQ-017 IDLE: when (dmemREN|dmemWEN)=1 and dhit=0, SHALL go to WAIT; when dhit=1, SHALL stay in IDLE.
REQ-018 WAIT: SHALL stay until dhit=1; on dhit with wben=1, SHALL go to IDLE; on dhit with wben=0, SHALL capture dmemload into ldbuf and go to HELD.
REQ-019 HELD: SHALL go to IDLE on the first cycle with wben=1.
REQ-020 mem_stall SHALL equal (dmemREN|dmemWEN) & ~dhit in IDLE and WAIT, and 0 in HELD; it is combinational with no added latency.
REQ-021 The WB register SHALL load when wben=1, mem_stall=0 and flush=0.
- Loaded fields: regWr, regSel, regDst, halt, valid=1, and the selected value.
- Loaded valid=0 when the load is a bubble.
REQ-022 Selected value by regSel: 0 ALUOut, 1 load data, 2 nPC, 3 lui.
- Load data = ldbuf in HELD, otherwise dmemload.
REQ-023 When mem_stall=1 and flush=0, the WB register SHALL load valid=0 (bubble) with regWr=0.
REQ-024 flush=1 SHALL clear the WB register to valid=0 and all fields 0, overriding wben.
REQ-025 flush SHALL NOT change FSM state or halt_out.
REQ-026 rf_WEN SHALL be valid_q & regWr_q & (regDst_q != 0); rf_wsel = regDst_q; rf_wdat = value_q. Latency is 1 cycle from MEM to WB.
REQ-027 halt_out SHALL set the cycle after a valid halt loads into WB, and stay 1 until reset.
REQ-028 Once halt_out=1, mem_stall SHALL remain 1 and rf_WEN SHALL be 0.

Reset
REQ-029 nRST=0 SHALL immediately force:
- FSM to IDLE, ldbuf=0, all WB register fields 0.
- rf_WEN=0, rf_wsel=0, rf_wdat=0, wb_valid=0, halt_out=0.
- mem_stall=(dmemREN|dmemWEN)&~dhit.
REQ-030 Reset during WAIT or HELD SHALL discard the pending access state; no write occurs after reset release without a new load.

Structure
REQ-031 word_t, regbits_t, the regsel_t enum (ALU, LOAD, NPC, LUI) and the wb_state_t enum SHALL live in the shared cpu_types_pkg.
REQ-032 The writeback value select SHALL be the sub-module wb_mux (purely combinational); FSM and registers stay in mem_wb_stage.

Verification
REQ-033 Inputs ALUOut=0x1234, regSel=0, regWr=1, regDst=5, wben=1, no memory access -> next cycle rf_WEN=1, rf_wsel=5, rf_wdat=0x1234.
REQ-034 Inputs dmemREN=1, dhit=0 for 3 cycles then dhit=1 with dmemload=0xCAFEF00D, regSel=1, regDst=8 -> mem_stall=1 for 3 cycles, then rf_wdat=0xCAFEF00D, rf_WEN=1 once.
REQ-035 dhit=1 arriving in WAIT with wben=0 for 2 cycles, dmemload then changing to 0 -> HELD entered, and the later write uses the captured 0xCAFEF00D.
REQ-036 flush=1 and wben=1 in the same cycle with regWr=1 -> wb_valid=0 and rf_WEN=0 next cycle.
REQ-037 regWr=1 with regDst=0 -> rf_WEN=0; halt=1 loaded -> halt_out=1 persists through a later flush, clears only on nRST.
REQ-038 nRST asserted mid-WAIT -> all outputs 0 immediately, FSM returns to IDLE, no spurious write after release.
